// File: rtl/board_ram_arbiter.sv
// ---------------------------------------------------------------------------
// board_ram_arbiter
//
// Shares the single-port board-state RAM (one word per minesweeper cell)
// between the VGA cell-fetch path and the game-logic engine. A clear
// sequencer zeroes the whole board after reset and whenever a new game is
// started. While clearing, both client ports are stalled.
//
// Optional feature (compile-time macro): BRAM_ARB_STARVE_GUARD_EN
//   Defined     : a wait counter tracks how long a game request has been
//                 blocked by VGA traffic. Once it reaches MAX_WAIT, the next
//                 slot goes to the game port even if VGA is requesting.
//   Not defined : strict VGA priority; the game port may starve.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   clear_start  in   pulse: restart the board clear from address 0
//   busy         out  high while the clear sweep is writing the RAM
//   vga_req      in   VGA cell-read request
//   vga_addr     in   VGA cell address
//   vga_gnt      out  VGA request accepted (same cycle as mem_* carry it)
//   vga_rvalid   out  vga_rdata valid, 2 cycles after vga_gnt
//   vga_rdata    out  VGA read data
//   gl_req       in   game request, held until gl_gnt
//   gl_we        in   1 = write gl_wdata, 0 = read
//   gl_addr      in   game cell address
//   gl_wdata     in   game write data
//   gl_gnt       out  game request accepted
//   gl_rvalid    out  gl_rdata valid, 2 cycles after gl_gnt (reads only)
//   gl_rdata     out  game read data
//   mem_addr     out  RAM address (registered)
//   mem_we       out  RAM write enable (registered)
//   mem_wdata    out  RAM write data (registered)
//   mem_rdata    in   RAM read data, valid 1 cycle after mem_addr
// ---------------------------------------------------------------------------
module board_ram_arbiter #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int CELL_W   = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    output logic              busy,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [CELL_W-1:0] vga_rdata,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [CELL_W-1:0] gl_wdata,
    output logic              gl_gnt,
    output logic              gl_rvalid,
    output logic [CELL_W-1:0] gl_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [CELL_W-1:0] mem_wdata,
    input  logic [CELL_W-1:0] mem_rdata
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_cur;
    logic              clr_go;
    logic              vga_sel;
    logic              gl_sel;
    logic              starved;
    logic              vga_vld_p2;
    logic              gl_vld_p1;
    logic              gl_vld_p2;

    // A clear_start pulse overrides everything and restarts the sweep at 0,
    // whether we are running or already part-way through a clear.
    assign clr_go  = clear_start || (state == CLEAR);
    assign clr_cur = clear_start ? '0 : clr_addr;

`ifdef BRAM_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    assign starved = (wait_cnt >= WAIT_W'(MAX_WAIT));

    // Counts edges at which a pending game request lost to VGA. Saturates at
    // MAX_WAIT so the forced slot is taken on the very next opportunity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (clr_go || !gl_req || gl_sel) begin
            wait_cnt <= '0;
        end else if (!starved) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // MAX_WAIT is only meaningful with the guard; a non-negative bound never
    // forces a game slot here, so VGA keeps strict priority.
    assign starved = (MAX_WAIT < 0);
`endif

    // Arbitration decision consumed at the next edge. A starved game request
    // takes the slot away from VGA for exactly one cycle.
    always_comb begin
        vga_sel = 1'b0;
        gl_sel  = 1'b0;
        if (!clr_go) begin
            if (gl_req && (starved || !vga_req)) begin
                gl_sel = 1'b1;
            end else if (vga_req) begin
                vga_sel = 1'b1;
            end
        end
    end

    // ---- stage p1: clear sweep / granted request registered onto mem_* ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            busy      <= 1'b0;
            vga_gnt   <= 1'b0;
            gl_gnt    <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            vga_gnt <= vga_sel;
            gl_gnt  <= gl_sel;
            if (clr_go) begin
                busy      <= 1'b1;
                mem_addr  <= clr_cur;
                mem_we    <= 1'b1;
                mem_wdata <= '0;
                clr_addr  <= clr_cur + 1'b1;
                state     <= (clr_cur == LAST_ADDR) ? RUN : CLEAR;
            end else begin
                busy  <= 1'b0;
                state <= RUN;
                if (vga_sel) begin
                    mem_addr  <= vga_addr;
                    mem_we    <= 1'b0;
                    mem_wdata <= '0;
                end else if (gl_sel) begin
                    mem_addr  <= gl_addr;
                    mem_we    <= gl_we;
                    mem_wdata <= gl_wdata;
                end else begin
                    mem_we <= 1'b0;
                end
            end
        end
    end

    // ---- stage p2: RAM is producing data for the reads issued in p1 ----
    // ---- stage p3: read data captured and presented with rvalid ----
    // In-flight reads keep flowing through these stages regardless of the
    // clear sequencer, so a read granted just before a clear still returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gl_vld_p1  <= 1'b0;
            vga_vld_p2 <= 1'b0;
            gl_vld_p2  <= 1'b0;
            vga_rvalid <= 1'b0;
            gl_rvalid  <= 1'b0;
            vga_rdata  <= '0;
            gl_rdata   <= '0;
        end else begin
            gl_vld_p1  <= gl_sel && !gl_we;
            vga_vld_p2 <= vga_gnt;
            gl_vld_p2  <= gl_vld_p1;
            vga_rvalid <= vga_vld_p2;
            gl_rvalid  <= gl_vld_p2;
            if (vga_vld_p2) begin
                vga_rdata <= mem_rdata;
            end
            if (gl_vld_p2) begin
                gl_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_ram_arbiter
//
// Bench for board_ram_arbiter. Provides a behavioural single-port RAM on the
// mem_* side and keeps its own reference copy of the board contents, fed at
// transaction level, to predict grants and read data.
// ---------------------------------------------------------------------------
module tb_board_ram_arbiter;

    localparam int DEPTH    = 256;
    localparam int ADDR_W   = 8;
    localparam int CELL_W   = 4;
    localparam int MAX_WAIT = 8;

`ifdef BRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear_start = 1'b0;
    logic              busy;
    logic              vga_req = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [CELL_W-1:0] vga_rdata;
    logic              gl_req = 1'b0;
    logic              gl_we = 1'b0;
    logic [ADDR_W-1:0] gl_addr = '0;
    logic [CELL_W-1:0] gl_wdata = '0;
    logic              gl_gnt;
    logic              gl_rvalid;
    logic [CELL_W-1:0] gl_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [CELL_W-1:0] mem_wdata;
    logic [CELL_W-1:0] mem_rdata;

    logic              fill_en = 1'b0;
    logic [CELL_W-1:0] ram [DEPTH];
    logic [CELL_W-1:0] ref_board [DEPTH];

    int n_assert = 0;
    int n_fail   = 0;

    board_ram_arbiter #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .CELL_W  (CELL_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_start(clear_start),
        .busy       (busy),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .gl_req     (gl_req),
        .gl_we      (gl_we),
        .gl_addr    (gl_addr),
        .gl_wdata   (gl_wdata),
        .gl_gnt     (gl_gnt),
        .gl_rvalid  (gl_rvalid),
        .gl_rdata   (gl_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-first, one-cycle read latency.
    // fill_en preloads nonzero junk so the clear sweep is observable.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= CELL_W'(i % 15 + 1);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1, "bench timed out");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_ref();
        for (int i = 0; i < DEPTH; i++) ref_board[i] = '0;
    endtask

    // Reset holds every output at 0, then the sweep writes 0 to 0..DEPTH-1
    // with busy high for exactly DEPTH cycles, ignoring pending requests.
    task automatic test_reset();
        int nz;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        fill_en = 1'b1;
        vga_req = 1'b1; vga_addr = 8'h20;
        gl_req = 1'b1; gl_we = 1'b1; gl_addr = 8'h10; gl_wdata = 4'h5;
        for (int i = 0; i < 3; i++) begin
            step();
            fill_en = 1'b0;
            n_assert++;
            if ({busy, vga_gnt, vga_rvalid, vga_rdata, gl_gnt, gl_rvalid, gl_rdata,
                 mem_addr, mem_we, mem_wdata} !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 0", {busy, vga_gnt, vga_rvalid,
                         vga_rdata, gl_gnt, gl_rvalid, gl_rdata, mem_addr, mem_we, mem_wdata});
            end
        end
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            n_assert++;
            if ({busy, mem_we, mem_addr, mem_wdata, vga_gnt, gl_gnt} !==
                {1'b1, 1'b1, ADDR_W'(i), CELL_W'(0), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_sweep[%0d]: got busy/we/addr/wdata/vgnt/ggnt %b/%b/%h/%h/%b/%b expected 1/1/%h/0/0/0",
                         i, busy, mem_we, mem_addr, mem_wdata, vga_gnt, gl_gnt, ADDR_W'(i));
            end
            if (i == DEPTH - 1) begin
                vga_req = 1'b0;
                gl_req  = 1'b0;
            end
        end
        step();
        n_assert++;
        if ({busy, mem_we, vga_gnt, gl_gnt} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_sweep_end: got busy/we/vgnt/ggnt %b expected 0000",
                     {busy, mem_we, vga_gnt, gl_gnt});
        end
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== '0) nz++;
        n_assert++;
        if (nz !== 0) begin
            n_fail++;
            $display("FAIL reset_ram_zero: got %0d nonzero cells expected 0", nz);
        end
        zero_ref();
    endtask

    // Game write then read of the same cell; read data arrives 2 cycles
    // after its grant and the write produces no rvalid.
    task automatic test_write_read();
        gl_req = 1'b1; gl_we = 1'b1; gl_addr = 8'h25; gl_wdata = 4'hA;
        step();
        n_assert++;
        if ({gl_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h25, 4'hA}) begin
            n_fail++;
            $display("FAIL wr_grant: got gnt/we/addr/wdata %b/%b/%h/%h expected 1/1/25/a",
                     gl_gnt, mem_we, mem_addr, mem_wdata);
        end
        ref_board[8'h25] = 4'hA;
        gl_we = 1'b0;
        step();
        n_assert++;
        if ({gl_gnt, mem_we, mem_addr, gl_rvalid} !== {1'b1, 1'b0, 8'h25, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_grant: got gnt/we/addr/rvalid %b/%b/%h/%b expected 1/0/25/0",
                     gl_gnt, mem_we, mem_addr, gl_rvalid);
        end
        gl_req = 1'b0;
        step();
        n_assert++;
        if (gl_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_no_rvalid: got %b expected 0", gl_rvalid);
        end
        step();
        n_assert++;
        if ({gl_rvalid, gl_rdata} !== {1'b1, 4'hA}) begin
            n_fail++;
            $display("FAIL rd_data: got rvalid/data %b/%h expected 1/a", gl_rvalid, gl_rdata);
        end
        step();
        n_assert++;
        if (gl_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_pulse: got %b expected 0", gl_rvalid);
        end
    endtask

    // Simultaneous requests: VGA first, the held game request the cycle after.
    task automatic test_priority();
        vga_req = 1'b1; vga_addr = 8'h25;
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 8'h30;
        step();
        n_assert++;
        if ({vga_gnt, gl_gnt, mem_addr} !== {1'b1, 1'b0, 8'h25}) begin
            n_fail++;
            $display("FAIL prio_vga: got vgnt/ggnt/addr %b/%b/%h expected 1/0/25",
                     vga_gnt, gl_gnt, mem_addr);
        end
        vga_req = 1'b0;
        step();
        n_assert++;
        if ({vga_gnt, gl_gnt, mem_addr} !== {1'b0, 1'b1, 8'h30}) begin
            n_fail++;
            $display("FAIL prio_gl: got vgnt/ggnt/addr %b/%b/%h expected 0/1/30",
                     vga_gnt, gl_gnt, mem_addr);
        end
        gl_req = 1'b0;
        step();
        n_assert++;
        if ({vga_rvalid, vga_rdata} !== {1'b1, ref_board[8'h25]}) begin
            n_fail++;
            $display("FAIL prio_vga_data: got %b/%h expected 1/%h", vga_rvalid, vga_rdata,
                     ref_board[8'h25]);
        end
        step();
        n_assert++;
        if ({gl_rvalid, gl_rdata} !== {1'b1, ref_board[8'h30]}) begin
            n_fail++;
            $display("FAIL prio_gl_data: got %b/%h expected 1/%h", gl_rvalid, gl_rdata,
                     ref_board[8'h30]);
        end
        step();
    endtask

    // Continuous VGA traffic against a held game request.
    task automatic test_starve();
        bit pend;
        bit eg;
        pend = 1'b1;
        vga_req = 1'b1;
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 8'h25;
        for (int k = 0; k < 20; k++) begin
            vga_addr = ADDR_W'(k);
            eg = pend && GUARD && (k == MAX_WAIT);
            step();
            n_assert++;
            if ({vga_gnt, gl_gnt} !== {!eg, eg}) begin
                n_fail++;
                $display("FAIL starve[%0d]: got vgnt/ggnt %b/%b expected %b/%b",
                         k, vga_gnt, gl_gnt, !eg, eg);
            end
            if (eg) begin
                pend = 1'b0;
                gl_req = 1'b0;
            end
        end
        vga_req = 1'b0;
        gl_req = 1'b0;
        for (int k = 0; k < 3; k++) step();
    endtask

    // Random mixed traffic checked against the reference board and a small
    // schedule of expected read returns.
    task automatic test_random(input int n);
        int   waited;
        logic ev, eg, gl_at_edge;
        bit   sv[4], sg[4];
        logic [CELL_W-1:0] dv[4], dg[4];
        int   s, d;
        waited = 0;
        for (int i = 0; i < 4; i++) begin
            sv[i] = 1'b0; sg[i] = 1'b0; dv[i] = '0; dg[i] = '0;
        end
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) begin
                vga_req  = ($urandom_range(0, 3) != 0);
                vga_addr = ADDR_W'($urandom_range(0, 31));
                if (!gl_req && ($urandom_range(0, 1) == 1)) begin
                    gl_req   = 1'b1;
                    gl_we    = 1'($urandom_range(0, 1));
                    gl_addr  = ADDR_W'($urandom_range(0, 31));
                    gl_wdata = CELL_W'($urandom);
                end
            end else begin
                vga_req = 1'b0;
                gl_req  = 1'b0;
            end
            eg = gl_req && (!vga_req || (GUARD && waited >= MAX_WAIT));
            ev = vga_req && !eg;
            gl_at_edge = gl_req;
            step();
            s = c % 4;
            d = (c + 2) % 4;
            n_assert++;
            if ({busy, vga_gnt, gl_gnt} !== {1'b0, ev, eg}) begin
                n_fail++;
                $display("FAIL rand_gnt[%0d]: got busy/vgnt/ggnt %b/%b/%b expected 0/%b/%b",
                         c, busy, vga_gnt, gl_gnt, ev, eg);
            end
            if (ev) begin
                n_assert++;
                if ({mem_we, mem_addr} !== {1'b0, vga_addr}) begin
                    n_fail++;
                    $display("FAIL rand_vga_mem[%0d]: got we/addr %b/%h expected 0/%h",
                             c, mem_we, mem_addr, vga_addr);
                end
                sv[d] = 1'b1;
                dv[d] = ref_board[vga_addr];
            end else if (eg) begin
                n_assert++;
                if ({mem_we, mem_addr} !== {gl_we, gl_addr} || (gl_we && mem_wdata !== gl_wdata)) begin
                    n_fail++;
                    $display("FAIL rand_gl_mem[%0d]: got we/addr/wdata %b/%h/%h expected %b/%h/%h",
                             c, mem_we, mem_addr, mem_wdata, gl_we, gl_addr, gl_wdata);
                end
                if (gl_we) begin
                    ref_board[gl_addr] = gl_wdata;
                end else begin
                    sg[d] = 1'b1;
                    dg[d] = ref_board[gl_addr];
                end
                gl_req = 1'b0;
            end else begin
                n_assert++;
                if (mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle_we[%0d]: got %b expected 0", c, mem_we);
                end
            end
            n_assert++;
            if (vga_rvalid !== sv[s] || (sv[s] && vga_rdata !== dv[s])) begin
                n_fail++;
                $display("FAIL rand_vga_rd[%0d]: got %b/%h expected %b/%h",
                         c, vga_rvalid, vga_rdata, sv[s], dv[s]);
            end
            n_assert++;
            if (gl_rvalid !== sg[s] || (sg[s] && gl_rdata !== dg[s])) begin
                n_fail++;
                $display("FAIL rand_gl_rd[%0d]: got %b/%h expected %b/%h",
                         c, gl_rvalid, gl_rdata, sg[s], dg[s]);
            end
            sv[s] = 1'b0;
            sg[s] = 1'b0;
            waited = (gl_at_edge && !eg) ? waited + 1 : 0;
        end
    endtask

    // New game mid-run: clear beats a simultaneous request, an in-flight read
    // still returns, and a second clear_start at address 100 restarts at 0.
    task automatic test_clear_restart();
        logic [CELL_W-1:0] exp_d;
        int nz;
        vga_req = 1'b1; vga_addr = 8'h25;
        step();
        exp_d = ref_board[8'h25];
        n_assert++;
        if (vga_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_pre_gnt: got %b expected 1", vga_gnt);
        end
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        n_assert++;
        if ({busy, mem_we, mem_addr, vga_gnt} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_start: got busy/we/addr/vgnt %b/%b/%h/%b expected 1/1/00/0",
                     busy, mem_we, mem_addr, vga_gnt);
        end
        step();
        n_assert++;
        if ({vga_rvalid, vga_rdata, mem_addr, vga_gnt} !== {1'b1, exp_d, 8'h01, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_inflight: got rvalid/data/addr/vgnt %b/%h/%h/%b expected 1/%h/01/0",
                     vga_rvalid, vga_rdata, mem_addr, vga_gnt, exp_d);
        end
        for (int i = 2; i <= 100; i++) begin
            step();
            n_assert++;
            if ({busy, mem_we, mem_addr, vga_gnt} !== {1'b1, 1'b1, ADDR_W'(i), 1'b0}) begin
                n_fail++;
                $display("FAIL clr_first[%0d]: got busy/we/addr/vgnt %b/%b/%h/%b expected 1/1/%h/0",
                         i, busy, mem_we, mem_addr, vga_gnt, ADDR_W'(i));
            end
        end
        clear_start = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            clear_start = 1'b0;
            n_assert++;
            if ({busy, mem_we, mem_addr, mem_wdata, vga_gnt} !==
                {1'b1, 1'b1, ADDR_W'(i), CELL_W'(0), 1'b0}) begin
                n_fail++;
                $display("FAIL clr_restart[%0d]: got busy/we/addr/wdata/vgnt %b/%b/%h/%h/%b expected 1/1/%h/0/0",
                         i, busy, mem_we, mem_addr, mem_wdata, vga_gnt, ADDR_W'(i));
            end
            if (i == DEPTH - 1) vga_req = 1'b0;
        end
        step();
        n_assert++;
        if ({busy, mem_we, vga_gnt} !== 3'b000) begin
            n_fail++;
            $display("FAIL clr_end: got busy/we/vgnt %b expected 000", {busy, mem_we, vga_gnt});
        end
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== '0) nz++;
        n_assert++;
        if (nz !== 0) begin
            n_fail++;
            $display("FAIL clr_ram_zero: got %0d nonzero cells expected 0", nz);
        end
        zero_ref();
    endtask

    // Reset while reads are in flight: everything drops at once, no rvalid
    // emerges, and the sweep starts again from address 0.
    task automatic test_reset_mid_read();
        vga_req = 1'b1; vga_addr = 8'h25;
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 8'h30;
        step();
        vga_req = 1'b0;
        step();
        gl_req = 1'b0;
        n_assert++;
        if (gl_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got gl_gnt %b expected 1", gl_gnt);
        end
        #2;
        reset = 1'b0;
        #1;
        n_assert++;
        if ({busy, vga_gnt, vga_rvalid, gl_gnt, gl_rvalid, mem_we, mem_addr} !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_mid_drop: got %h expected 0",
                     {busy, vga_gnt, vga_rvalid, gl_gnt, gl_rvalid, mem_we, mem_addr});
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_assert++;
            if ({vga_rvalid, gl_rvalid, vga_gnt, gl_gnt, busy} !== 5'b00000) begin
                n_fail++;
                $display("FAIL rst_mid_hold[%0d]: got rv/grv/vg/gg/busy %b expected 00000",
                         k, {vga_rvalid, gl_rvalid, vga_gnt, gl_gnt, busy});
            end
        end
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            n_assert++;
            if ({busy, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, ADDR_W'(i), CELL_W'(0)}) begin
                n_fail++;
                $display("FAIL rst_mid_sweep[%0d]: got busy/we/addr/wdata %b/%b/%h/%h expected 1/1/%h/0",
                         i, busy, mem_we, mem_addr, mem_wdata, ADDR_W'(i));
            end
        end
        step();
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_end: got busy %b expected 0", busy);
        end
        zero_ref();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_starve();
        test_random(400);
        test_clear_restart();
        test_random(150);
        test_reset_mid_read();
        test_random(150);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
